// File: rtl/led_fader.sv
// PWM fader for the four LED pattern bits: each channel level ramps toward
// 0 or MAX in FADE_STEP increments every STEP_DIV cycles, and drives its pin by PWM.
module led_fader #(
    parameter int PWM_BITS  = 8,
    parameter int STEP_DIV  = 39062,
    parameter int FADE_STEP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_pattern,
    input  logic       i_instant,
    output logic       o_led1,
    output logic       o_led2,
    output logic       o_led3,
    output logic       o_led4,
    output logic       o_busy
);

    localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS:0]   STEP_X   = (PWM_BITS + 1)'(FADE_STEP);

    logic [3:0]          pat_r;
    logic [PRE_W-1:0]    prescaler_r;
    logic                step_tick_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [PWM_BITS-1:0] level_r     [4];
    logic [3:0]          led_r;
    logic                busy_r;

    logic [PWM_BITS-1:0] target_s    [4];
    logic [PWM_BITS-1:0] level_nxt_s [4];
    logic [3:0]          led_nxt_s;
    logic                busy_nxt_s;

    // One fade step toward tgt, computed one bit wider so nothing wraps, then clamped.
    function automatic logic [PWM_BITS-1:0] fade_next(
        input logic [PWM_BITS-1:0] cur,
        input logic [PWM_BITS-1:0] tgt
    );
        logic [PWM_BITS:0] cur_x;
        logic [PWM_BITS:0] tgt_x;
        logic [PWM_BITS:0] up_x;
        logic [PWM_BITS:0] res_x;
        cur_x = {1'b0, cur};
        tgt_x = {1'b0, tgt};
        up_x  = cur_x + STEP_X;
        if (cur_x < tgt_x) begin
            res_x = (up_x > tgt_x) ? tgt_x : up_x;
        end else if (cur_x > tgt_x) begin
            res_x = (cur_x < (tgt_x + STEP_X)) ? tgt_x : (cur_x - STEP_X);
        end else begin
            res_x = cur_x;
        end
        return res_x[PWM_BITS-1:0];
    endfunction

    // Targets, next levels, and the next registered LED/busy values.
    always_comb begin
        busy_nxt_s = 1'b0;
        led_nxt_s  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            target_s[i]    = pat_r[i] ? MAX : '0;
            level_nxt_s[i] = level_r[i];
            if (i_instant) begin
                level_nxt_s[i] = target_s[i];
            end else if (step_tick_r) begin
                level_nxt_s[i] = fade_next(level_r[i], target_s[i]);
            end else begin
                level_nxt_s[i] = level_r[i];
            end
            busy_nxt_s   = busy_nxt_s | (level_r[i] != target_s[i]);
            led_nxt_s[i] = (level_r[i] == MAX) | (level_r[i] > pwm_cnt_r);
        end
    end

    // Pattern capture, step prescaler and free-running PWM counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_r       <= 4'b0000;
            prescaler_r <= '0;
            step_tick_r <= 1'b0;
            pwm_cnt_r   <= '0;
        end else begin
            pat_r       <= i_pattern;
            prescaler_r <= (prescaler_r == PRE_LAST) ? '0 : (prescaler_r + PRE_W'(1));
            step_tick_r <= (prescaler_r == PRE_LAST);
            pwm_cnt_r   <= pwm_cnt_r + PWM_BITS'(1);
        end
    end

    // Channel levels and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                level_r[i] <= '0;
            end
            led_r  <= 4'b0000;
            busy_r <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                level_r[i] <= level_nxt_s[i];
            end
            led_r  <= led_nxt_s;
            busy_r <= busy_nxt_s;
        end
    end

    assign o_led1 = led_r[0];
    assign o_led2 = led_r[1];
    assign o_led3 = led_r[2];
    assign o_led4 = led_r[3];
    assign o_busy = busy_r;

endmodule
